// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Main control FSM of the multi-cycle 32-bit MIPS core. Each instruction is
// sequenced through FETCH / DECODE / EXEC / MEM / WB, driving the shared
// memory, ALU, PC and register-file controls. It waits on variable-latency
// instruction and data memories, with an optional wait timeout, and counts
// retired instructions.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active high
//   opcode      in   instruction[31:26]; only looked at in DECODE
//   imem_ready  in   instruction memory data valid
//   dmem_ready  in   data memory access complete
//   zero        in   ALU zero flag; only looked at in EXEC
//   imem_read   out  instruction fetch request
//   ir_write    out  load the IR
//   pc_write    out  update the PC
//   pc_src      out  00 pc+4, 01 branch target, 10 jump target
//   dmem_read   out  data load request
//   dmem_write  out  data store request
//   alu_src     out  1 = immediate operand
//   alu_op      out  00 add, 01 sub, 10 or, 11 funct-decoded
//   r_type      out  R-type qualifier (EXEC..WB)
//   ori         out  ori qualifier (EXEC..WB)
//   lui         out  lui qualifier (EXEC..WB)
//   mem_to_reg  out  writeback data comes from memory
//   reg_write   out  register file write
//   reg_write2  out  hi/lo write (R-type)
//   link        out  jal: write pc+4 to $31
//   illegal     out  one-cycle pulse on an unknown opcode
//   bus_error   out  one-cycle pulse on a memory wait timeout
//   state       out  current FSM state (debug)
//   retired     out  retired-instruction count, wraps
//
// Handshake: a memory request (imem_read / dmem_read / dmem_write) is held
// high every cycle the FSM sits in the requesting state; the access
// completes in the cycle the matching ready is seen high. Only the ready of
// the current state is honoured. If the timeout fires first the request is
// simply dropped and the FSM returns to FETCH.
// ---------------------------------------------------------------------------
module multicycle_controller #(
   parameter int COUNT_W     = 32,
   parameter int MEM_TIMEOUT = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               imem_ready,
   input  logic               dmem_ready,
   input  logic               zero,
   output logic               imem_read,
   output logic               ir_write,
   output logic               pc_write,
   output logic [1:0]         pc_src,
   output logic               dmem_read,
   output logic               dmem_write,
   output logic               alu_src,
   output logic [1:0]         alu_op,
   output logic               r_type,
   output logic               ori,
   output logic               lui,
   output logic               mem_to_reg,
   output logic               reg_write,
   output logic               reg_write2,
   output logic               link,
   output logic               illegal,
   output logic               bus_error,
   output logic [2:0]         state,
   output logic [COUNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4
   } state_t;

   localparam logic [5:0] OP_R   = 6'b000000;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_JAL = 6'b000011;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LUI = 6'b001111;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam bit          TIMEOUT_EN  = (MEM_TIMEOUT != 0);
   localparam logic [31:0] TIMEOUT_LIM = 32'(MEM_TIMEOUT);

   state_t             state_q;
   state_t             state_d;
   logic [5:0]         op_q;
   logic [5:0]         cur_op;
   logic [COUNT_W-1:0] retired_q;
   logic [31:0]        wait_cnt;
   logic               waiting;
   logic               timeout;
   logic               retire;

   logic is_r, is_j, is_jal, is_beq, is_bne, is_ori, is_lui, is_lw, is_sw;
   logic known;

   // The opcode is latched at the end of DECODE, so DECODE itself has to
   // decode the live IR field; every later state uses the latched copy.
   assign cur_op = (state_q == S_DECODE) ? opcode : op_q;

   assign is_r   = (cur_op == OP_R);
   assign is_j   = (cur_op == OP_J);
   assign is_jal = (cur_op == OP_JAL);
   assign is_beq = (cur_op == OP_BEQ);
   assign is_bne = (cur_op == OP_BNE);
   assign is_ori = (cur_op == OP_ORI);
   assign is_lui = (cur_op == OP_LUI);
   assign is_lw  = (cur_op == OP_LW);
   assign is_sw  = (cur_op == OP_SW);
   assign known  = is_r | is_j | is_jal | is_beq | is_bne |
                   is_ori | is_lui | is_lw | is_sw;

   // A waiting cycle is one spent in a memory state without its ready.
   assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                    ((state_q == S_MEM)   && !dmem_ready);

   // Timeout fires in the waiting cycle that finds the counter already at
   // the limit; a ready in that cycle means waiting is low, so it wins.
   assign timeout = TIMEOUT_EN && waiting && (wait_cnt == TIMEOUT_LIM);

   // -------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         op_q      <= '0;
         retired_q <= '0;
         wait_cnt  <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
         if (retire) begin
            retired_q <= retired_q + COUNT_W'(1);
         end
         // A timeout returns FETCH to FETCH, so it must clear explicitly.
         if (timeout || (state_d != state_q)) begin
            wait_cnt <= '0;
         end else if (waiting) begin
            wait_cnt <= wait_cnt + 32'd1;
         end
      end
   end

   // -------------------------------------------------------------------
   // Next-state and retirement
   // -------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               state_d = S_DECODE;
            end else if (timeout) begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            if (is_j) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end else if (is_jal) begin
               state_d = S_WB;
            end else if (!known) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (is_beq || is_bne) begin
               state_d = S_FETCH;
               retire  = 1'b1;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (is_sw) begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end else begin
                  state_d = S_WB;
               end
            end else if (timeout) begin
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            state_d = S_FETCH;
            retire  = 1'b1;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // -------------------------------------------------------------------
   // Output decode; everything is forced low while rst is high so an
   // interrupted access issues no strobes.
   // -------------------------------------------------------------------
   always_comb begin
      imem_read  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      alu_src    = 1'b0;
      alu_op     = 2'b00;
      r_type     = 1'b0;
      ori        = 1'b0;
      lui        = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      reg_write2 = 1'b0;
      link       = 1'b0;
      illegal    = 1'b0;
      bus_error  = 1'b0;
      state      = 3'd0;
      retired    = '0;
      if (!rst) begin
         state     = state_q;
         retired   = retired_q;
         bus_error = timeout;
         case (state_q)
            S_FETCH: begin
               imem_read = 1'b1;
               if (imem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  pc_src   = 2'b00;
               end
            end
            S_DECODE: begin
               if (is_j) begin
                  pc_write = 1'b1;
                  pc_src   = 2'b10;
               end else if (!known) begin
                  illegal = 1'b1;
               end
            end
            S_EXEC: begin
               if (is_r) begin
                  alu_op = 2'b11;
               end else if (is_lw || is_sw || is_lui) begin
                  alu_op  = 2'b00;
                  alu_src = 1'b1;
               end else if (is_ori) begin
                  alu_op  = 2'b10;
                  alu_src = 1'b1;
               end else if (is_beq || is_bne) begin
                  alu_op   = 2'b01;
                  pc_src   = 2'b01;
                  pc_write = is_beq ? zero : ~zero;
               end
            end
            S_MEM: begin
               dmem_read  = is_lw;
               dmem_write = is_sw;
            end
            S_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = is_lw;
               reg_write2 = is_r;
               if (is_jal) begin
                  link     = 1'b1;
                  pc_write = 1'b1;
                  pc_src   = 2'b10;
               end
            end
            default: begin
            end
         endcase
         if ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB)) begin
            r_type = is_r;
            ori    = is_ori;
            lui    = is_lui;
         end
      end
   end

endmodule
